// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder slice.
//   SPI_BYTE_W   - bits per SPI byte
//   DEFAULT_FILL - byte sent when the transmit side has nothing queued
//   spi_state_e  - responder frame state (IDLE / ACTIVE)
//   tx_pick_t    - result of choosing the next byte to shift out
//   tx_consume() - the byte-selection rule used at frame start and byte boundaries
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned BIT_CNT_W  = $clog2(SPI_BYTE_W);
    localparam logic [SPI_BYTE_W-1:0] DEFAULT_FILL = 8'hFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic [SPI_BYTE_W-1:0] data;
        logic                  underrun;
    } tx_pick_t;

    // Priority: a queued holding byte, then a byte being written this very cycle
    // (bypass), otherwise the fill byte with an underrun flag.
    function automatic tx_pick_t tx_consume(
        input logic                  hold_full,
        input logic [SPI_BYTE_W-1:0] hold,
        input logic                  load,
        input logic [SPI_BYTE_W-1:0] load_data,
        input logic [SPI_BYTE_W-1:0] fill
    );
        tx_pick_t pick;
        if (hold_full) begin
            pick.data     = hold;
            pick.underrun = 1'b0;
        end else if (load) begin
            pick.data     = load_data;
            pick.underrun = 1'b0;
        end else begin
            pick.data     = fill;
            pick.underrun = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with registered-copy edge detection.
//   clk      - system clock
//   reset_in - asynchronous active-low reset
//   d        - asynchronous input
//   rise     - high for one clk cycle after the synchronised input goes 0->1
//   fall     - high for one clk cycle after the synchronised input goes 1->0
// SYNC_STAGES must be at least 2. RESET_VAL is the value the chain (and the edge
// reference copy) holds during reset, so no edge is reported if the input already
// sits at that level when reset is released.
module sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_in,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= synced;
        end
    end

    assign rise = synced & ~prev_q;
    assign fall = ~synced & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target, byte oriented, run entirely from the system clock.
//   clk, reset_in        - system clock, asynchronous active-low reset
//   spi_clk/cs/mosi      - SPI pins from the master (oversampled)
//   spi_miso, _oe        - target data out (MSB first) and its tri-state enable
//   rx_data, rx_valid    - last complete received byte and its one-cycle strobe
//   tx_data, tx_load     - byte write into the one-deep holding register
//   tx_ready             - holding register empty
//   tx_underrun          - strobe when the fill byte had to be sent
//   frame_start/_end     - strobes on synchronised CS fall / rise
//   frame_partial        - with frame_end: the frame stopped mid-byte
module spi_responder
    import spi_pkg::*;
#(
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = DEFAULT_FILL
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  spi_clk,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_partial
);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b0)
    ) u_sync_sclk (
        .clk     (clk),
        .reset_in(reset_in),
        .d       (spi_clk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // CS resets low: a CS already low at reset release produces no fall, so no
    // frame starts until the master deselects and reselects. The rise seen when
    // CS is high at release lands in IDLE and is ignored.
    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b0)
    ) u_sync_cs (
        .clk     (clk),
        .reset_in(reset_in),
        .d       (spi_cs),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    // Same depth as the SCLK chain so MOSI is sampled in step with SCLK.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_state_e              state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-2:0]   rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [SPI_BYTE_W-1:0]   shift_out_q, shift_out_d;
    logic [SPI_BYTE_W-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    tx_underrun_q, tx_underrun_d;
    logic                    frame_start_q, frame_start_d;
    logic                    frame_end_q, frame_end_d;
    logic                    frame_partial_q, frame_partial_d;

    logic                    consume;
    tx_pick_t                pick;

    assign pick = tx_consume(hold_full_q, hold_q, tx_load, tx_data, FILL_BYTE);

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        rx_shift_d      = rx_shift_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        shift_out_d     = shift_out_q;
        hold_d          = hold_q;
        hold_full_d     = hold_full_q;
        tx_underrun_d   = 1'b0;
        frame_start_d   = 1'b0;
        frame_end_d     = 1'b0;
        frame_partial_d = 1'b0;
        consume         = 1'b0;

        unique case (state_q)
            IDLE: begin
                // SCLK edges are ignored here.
                if (cs_fall) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                    bit_cnt_d     = '0;
                    consume       = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // Deselect wins over any SCLK edge in the same cycle; partial
                    // rx bits are dropped.
                    state_d         = IDLE;
                    frame_end_d     = 1'b1;
                    frame_partial_d = (bit_cnt_q != '0);
                    bit_cnt_d       = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[SPI_BYTE_W-3:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_CNT_W'(SPI_BYTE_W - 1)) begin
                            rx_data_d  = {rx_shift_q, mosi_s};
                            rx_valid_d = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        // A fall at count 0 follows the 8th rise: next byte's MSB.
                        if (bit_cnt_q == '0) begin
                            consume = 1'b1;
                        end else begin
                            shift_out_d = {shift_out_q[SPI_BYTE_W-2:0], 1'b1};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume) begin
            shift_out_d   = pick.data;
            tx_underrun_d = pick.underrun;
        end

        // Holding register: emptied when consumed; a write while empty is stored
        // unless it was consumed directly as a bypass in the same cycle. A write
        // while full is dropped.
        if (consume && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (tx_load && !hold_full_q && !consume) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            rx_shift_q      <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            shift_out_q     <= FILL_BYTE;
            hold_q          <= FILL_BYTE;
            hold_full_q     <= 1'b0;
            tx_underrun_q   <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_end_q     <= 1'b0;
            frame_partial_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            shift_out_q     <= shift_out_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            tx_underrun_q   <= tx_underrun_d;
            frame_start_q   <= frame_start_d;
            frame_end_q     <= frame_end_d;
            frame_partial_q <= frame_partial_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_miso_oe   = (state_q == ACTIVE);
    assign spi_miso      = (state_q == ACTIVE) ? shift_out_q[SPI_BYTE_W-1] : 1'b1;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign tx_ready      = ~hold_full_q;
    assign tx_underrun   = tx_underrun_q;
    assign frame_start   = frame_start_q;
    assign frame_end     = frame_end_q;
    assign frame_partial = frame_partial_q;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: a mode-0 master model at clk/8 with
// scoreboard queues for expected received bytes and expected MISO bytes.
module tb_spi_responder;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 4;

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_start;
    logic       frame_end;
    logic       frame_partial;

    always #5 clk = ~clk;

    spi_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILL_BYTE  (8'hFF)
    ) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .spi_clk      (spi_clk),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .tx_ready     (tx_ready),
        .tx_underrun  (tx_underrun),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .frame_partial(frame_partial)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters, updated only by tick().
    int   n_rx = 0, n_underrun = 0, n_fstart = 0, n_fend = 0, n_notready = 0, n_stray = 0;
    logic last_partial = 1'b0;
    int   b_rx, b_underrun, b_fstart, b_fend;
    int   nr_snap = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] mosi_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling clk edge and observe DUT strobes there.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (rx_valid) begin
            n_rx++;
            check_eq("rx_pending", 32'(exp_rx.size() != 0), 1);
            if (exp_rx.size() != 0) begin
                e = exp_rx.pop_front();
                check_eq("rx_data", 32'(rx_data), 32'(e));
            end
        end
        if (tx_underrun) n_underrun++;
        if (frame_start) n_fstart++;
        if (frame_end) begin
            n_fend++;
            last_partial = frame_partial;
        end
        if (frame_partial && !frame_end) n_stray++;
        if (!tx_ready) n_notready++;
    endtask

    task automatic snap();
        b_rx       = n_rx;
        b_underrun = n_underrun;
        b_fstart   = n_fstart;
        b_fend     = n_fend;
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        tick();
        check_eq("tx_ready_after_load", 32'(tx_ready), 0);
    endtask

    // One CS-framed transfer of nbits. MOSI bytes come from mosi_q; each complete
    // MISO byte is compared against exp_miso. If byp_idx >= 0, byp_val is written
    // exactly in the cycle the responder reloads after byte byp_idx. The final
    // SCLK fall coincides with CS rise so no trailing reload occurs.
    task automatic spi_frame(input int nbits, input int byp_idx, input logic [7:0] byp_val);
        logic [7:0] out_b;
        logic [7:0] in_b;
        logic [7:0] e;
        out_b  = 8'h00;
        in_b   = 8'h00;
        spi_cs = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < nbits; i++) begin
            if (i % 8 == 0) out_b = (mosi_q.size() != 0) ? mosi_q.pop_front() : 8'h00;
            spi_mosi = out_b[7 - (i % 8)];
            repeat (HALF) tick();
            in_b    = {in_b[6:0], spi_miso};
            spi_clk = 1'b1;
            if (i % 8 == 7) begin
                check_eq("miso_pending", 32'(exp_miso.size() != 0), 1);
                if (exp_miso.size() != 0) begin
                    e = exp_miso.pop_front();
                    check_eq("miso_byte", 32'(in_b), 32'(e));
                end
            end
            repeat (HALF) tick();
            spi_clk = 1'b0;
            if (i == nbits - 1) begin
                spi_cs = 1'b1;
            end else if (i % 8 == 7 && i / 8 == byp_idx) begin
                nr_snap = n_notready;
                // Synchronised fall is seen after SYNC_STAGES edges.
                repeat (SYNC_STAGES) tick();
                tx_data = byp_val;
                tx_load = 1'b1;
                tick();
                tx_load = 1'b0;
            end
        end
        repeat (12) tick();
    endtask

    initial begin
        // ---------------- Reset values ----------------
        reset_in = 1'b0;
        repeat (3) tick();
        check_eq("rst_miso", 32'(spi_miso), 1);
        check_eq("rst_oe", 32'(spi_miso_oe), 0);
        check_eq("rst_rx_data", 32'(rx_data), 0);
        check_eq("rst_rx_valid", 32'(rx_valid), 0);
        check_eq("rst_tx_ready", 32'(tx_ready), 1);
        check_eq("rst_underrun", 32'(tx_underrun), 0);
        check_eq("rst_fstart", 32'(frame_start), 0);
        check_eq("rst_fend", 32'(frame_end), 0);
        check_eq("rst_fpartial", 32'(frame_partial), 0);
        reset_in = 1'b1;
        snap();
        repeat (100) tick();
        check_eq("idle_rx", n_rx - b_rx, 0);
        check_eq("idle_underrun", n_underrun - b_underrun, 0);
        check_eq("idle_fstart", n_fstart - b_fstart, 0);
        check_eq("idle_fend", n_fend - b_fend, 0);
        check_eq("idle_oe", 32'(spi_miso_oe), 0);
        check_eq("idle_miso", 32'(spi_miso), 1);
        check_eq("idle_tx_ready", 32'(tx_ready), 1);

        // ---------------- Single byte: tx A5, rx 3C ----------------
        load_tx(8'hA5);
        mosi_q.push_back(8'h3C);
        exp_rx.push_back(8'h3C);
        exp_miso.push_back(8'hA5);
        snap();
        spi_frame(8, -1, 8'h00);
        check_eq("b1_rx_cnt", n_rx - b_rx, 1);
        check_eq("b1_rx_data", 32'(rx_data), 32'h3C);
        check_eq("b1_fstart", n_fstart - b_fstart, 1);
        check_eq("b1_fend", n_fend - b_fend, 1);
        check_eq("b1_partial", 32'(last_partial), 0);
        check_eq("b1_underrun", n_underrun - b_underrun, 0);
        check_eq("b1_tx_ready", 32'(tx_ready), 1);

        // ---------------- Three bytes, one preloaded ----------------
        load_tx(8'h55);
        mosi_q.push_back(8'h01);
        mosi_q.push_back(8'h02);
        mosi_q.push_back(8'h03);
        exp_rx.push_back(8'h01);
        exp_rx.push_back(8'h02);
        exp_rx.push_back(8'h03);
        exp_miso.push_back(8'h55);
        exp_miso.push_back(8'hFF);
        exp_miso.push_back(8'hFF);
        snap();
        spi_frame(24, -1, 8'h00);
        check_eq("b3_rx_cnt", n_rx - b_rx, 3);
        check_eq("b3_underrun", n_underrun - b_underrun, 2);
        check_eq("b3_partial", 32'(last_partial), 0);

        // ---------------- Bypass at byte boundary ----------------
        load_tx(8'h96);
        mosi_q.push_back(8'hA1);
        mosi_q.push_back(8'hB2);
        exp_rx.push_back(8'hA1);
        exp_rx.push_back(8'hB2);
        exp_miso.push_back(8'h96);
        exp_miso.push_back(8'h7E);
        snap();
        spi_frame(16, 0, 8'h7E);
        check_eq("byp_underrun", n_underrun - b_underrun, 0);
        check_eq("byp_ready_drop", n_notready - nr_snap, 0);
        check_eq("byp_tx_ready", 32'(tx_ready), 1);
        check_eq("byp_rx_cnt", n_rx - b_rx, 2);

        // ---------------- Partial frame then aligned frame ----------------
        mosi_q.push_back(8'hF0);
        snap();
        spi_frame(5, -1, 8'h00);
        check_eq("part_rx_cnt", n_rx - b_rx, 0);
        check_eq("part_fend", n_fend - b_fend, 1);
        check_eq("part_partial", 32'(last_partial), 1);
        check_eq("part_underrun", n_underrun - b_underrun, 1);
        load_tx(8'h3A);
        mosi_q.push_back(8'hC3);
        exp_rx.push_back(8'hC3);
        exp_miso.push_back(8'h3A);
        snap();
        spi_frame(8, -1, 8'h00);
        check_eq("after_part_rx_cnt", n_rx - b_rx, 1);
        check_eq("after_part_rx_data", 32'(rx_data), 32'hC3);
        check_eq("after_part_partial", 32'(last_partial), 0);

        // ---------------- Reset mid-byte ----------------
        load_tx(8'h24);
        spi_cs = 1'b0;
        repeat (6) tick();
        load_tx(8'h42);
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            repeat (HALF) tick();
            spi_clk = 1'b1;
            repeat (HALF) tick();
            if (i < 2) spi_clk = 1'b0;
        end
        check_eq("pre_rst_oe", 32'(spi_miso_oe), 1);
        #3;
        reset_in = 1'b0;
        #1;
        check_eq("mid_rst_oe", 32'(spi_miso_oe), 0);
        check_eq("mid_rst_miso", 32'(spi_miso), 1);
        check_eq("mid_rst_tx_ready", 32'(tx_ready), 1);
        check_eq("mid_rst_rx_data", 32'(rx_data), 0);
        check_eq("mid_rst_underrun", 32'(tx_underrun), 0);
        spi_clk = 1'b0;
        repeat (2) tick();
        reset_in = 1'b1;
        snap();
        repeat (20) tick();
        check_eq("post_rst_no_start", n_fstart - b_fstart, 0);
        check_eq("post_rst_oe", 32'(spi_miso_oe), 0);
        spi_cs = 1'b1;
        repeat (10) tick();
        check_eq("post_rst_no_end", n_fend - b_fend, 0);
        load_tx(8'h81);
        mosi_q.push_back(8'h5A);
        exp_rx.push_back(8'h5A);
        exp_miso.push_back(8'h81);
        snap();
        spi_frame(8, -1, 8'h00);
        check_eq("post_rst_rx_cnt", n_rx - b_rx, 1);
        check_eq("post_rst_rx_data", 32'(rx_data), 32'h5A);
        check_eq("post_rst_fend", n_fend - b_fend, 1);

        // ---------------- Scoreboard drained ----------------
        check_eq("exp_rx_left", exp_rx.size(), 0);
        check_eq("exp_miso_left", exp_miso.size(), 0);
        check_eq("stray_partial", n_stray, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
